// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with ten single-cycle ops and an iterative
// shift-add multiply. Valid/ready handshake on both operand and result sides.
// Result, eq and zero are held stable from completion until transferred.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  eq,
    output logic                  zero
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = $clog2(DATA_WIDTH + 1);

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(10);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t                state_q,  state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  eq_q,     eq_d;
    logic                  zero_q,   zero_d;
    logic [DATA_WIDTH-1:0] mcand_q,  mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q,    acc_d;
    logic [CW-1:0]         count_q,  count_d;

    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic [SHW-1:0]        shamt;

    // Single-cycle datapath: combinational result for the presented op.
    always_comb begin
        alu_res = '0;
        shamt   = op2[SHW-1:0];
        case (alu_op)
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
            OP_SLL:  alu_res = op1 << shamt;
            OP_SRL:  alu_res = op1 >> shamt;
            OP_SRA:  alu_res = $signed(op1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Control FSM: next state, handshake outputs and datapath register updates.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        eq_d      = eq_q;
        zero_d    = zero_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        acc_sum   = acc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_MUL: begin
                acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept overrides the IDLE/DONE defaults so a transfer and a new
        // accept can share one edge.
        if (in_valid && in_ready) begin
            eq_d = (op1 == op2);
            if (alu_op == OP_MUL) begin
                mcand_d  = op1;
                mplier_d = op2;
                acc_d    = '0;
                count_d  = CW'(DATA_WIDTH);
                state_d  = S_MUL;
            end else begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                state_d  = S_DONE;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            eq_q     <= 1'b0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            eq_q     <= eq_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign result = result_q;
    assign eq     = eq_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        eq;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic        eq;
    } exp_t;

    exp_t exp_q[$];

    alu_multicycle #(
        .DATA_WIDTH(32),
        .OP_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .eq        (eq),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operation definitions.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned prod;
        int unsigned     amt;
        amt = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << amt;
            4'd8:    return a >> amt;
            4'd9:    return 32'(int'(a) >>> amt);
            4'd10: begin
                prod = longint'(a) * longint'(b);
                return prod[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    // One operation with out_ready held high: present, await result, check.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] e;
        int          cyc;
        int          busy_bad;
        e = model(op, a, b);
        @(negedge clk);
        alu_op   = op;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc      = 0;
        busy_bad = 0;
        @(negedge clk);
        while (!out_valid && cyc < 100) begin
            if (in_ready) busy_bad++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, cyc, (op == 4'd10) ? 32 : 0);
        if (op == 4'd10) chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_res"}, result, e);
        chk({tag, "_eq"}, eq, (a == b));
        chk({tag, "_zero"}, zero, (e == 32'd0));
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        x;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = '0;
        op1       = '0;
        op2       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_eq", eq, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        // Directed operations
        run_op(4'd0,  32'd5,         32'd7,         "add");
        run_op(4'd1,  32'd9,         32'd9,         "sub");
        run_op(4'd10, 32'hFFFF_FFFF, 32'd3,         "mul_a");
        run_op(4'd10, 32'h0001_0000, 32'h0001_0000, "mul_b");
        run_op(4'd9,  32'h8000_0000, 32'd36,        "sra");
        run_op(4'd8,  32'h8000_0000, 32'd36,        "srl");
        run_op(4'd7,  32'h0000_0003, 32'd33,        "sll");
        run_op(4'd5,  32'hFFFF_FFFF, 32'd1,         "slt");
        run_op(4'd6,  32'hFFFF_FFFF, 32'd1,         "sltu");
        run_op(4'd13, 32'd4,         32'd4,         "rsvd");
        chk("sra_const", result, 32'd0);

        // Backpressure with same-edge transfer and accept
        @(negedge clk);
        out_ready = 1'b0;
        alu_op    = 4'd0;
        op1       = 32'd1;
        op2       = 32'd1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", result, 32'd2);
            chk("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        alu_op    = 4'd4;
        op1       = 32'h0000_F0F0;
        op2       = 32'h0000_0FF0;
        in_valid  = 1'b1;
        #1 chk("bp_ready_comb", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_res", result, 32'h0000_FF00);
        chk("bp_next_zero", zero, 0);

        // Streaming random single-cycle ops, one per cycle
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (i > 0) begin
                x = exp_q.pop_front();
                chk("str_valid", out_valid, 1);
                chk("str_res", result, x.res);
                chk("str_eq", eq, x.eq);
                chk("str_zero", zero, (x.res == 32'd0));
            end
            if (i < 100) begin
                op = 4'($urandom_range(0, 14));
                if (op >= 4'd10) op = op + 4'd1;
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                if ($urandom_range(0, 3) == 0) b = b & 32'h3F;
                alu_op   = op;
                op1      = a;
                op2      = b;
                in_valid = 1'b1;
                chk("str_ready", in_ready, 1);
                x.res = model(op, a, b);
                x.eq  = (a == b);
                exp_q.push_back(x);
            end else begin
                in_valid = 1'b0;
            end
        end

        // Random multiplies
        for (int i = 0; i < 4; i++) begin
            run_op(4'd10, $urandom, $urandom, "mul_rnd");
        end

        // Reset in the middle of a multiply
        run_op(4'd0, 32'd100, 32'd23, "pre_rst");
        @(negedge clk);
        alu_op   = 4'd10;
        op1      = 32'd7;
        op2      = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_result", result, 0);
        chk("mrst_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("mrst_novalid", out_valid, 0);
        end
        chk("mrst_ready_post", in_ready, 1);
        run_op(4'd0, 32'd2, 32'd3, "post_rst");

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
